// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator for the byte-addressed data RAM (IDLE -> ACCESS -> RESP).
// Optional build macro MISALIGN_TRAP_EN: misaligned h/w accesses skip the RAM and return resp_err.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              stall_req,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic                store_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic                illegal, misalign, err;
  logic [3:0]          sel_w;
  logic [DATA_W-1:0]   wdata_w, load_res;
  logic [7:0]          b0, b1, b2, b3;

  // Stores only support b/h/w; loads additionally allow bu/hu.
  assign illegal  = store_q ? (f3_q >= 3'b011)
                            : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
  assign misalign = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                    (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
  assign err = illegal || misalign;
`else
  assign err = illegal;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ACCESS && !store_q && !err)
        rdata_q <= ram_rdata;
    end
  end

  // RAM lane 0 ([31:24]) holds the byte at ram_addr, so store data is byte-reversed.
  always_comb begin
    sel_w   = 4'b1111;
    wdata_w = '0;
    if (store_q) begin
      case (f3_q[1:0])
        2'b00:   begin sel_w = 4'b1000; wdata_w = {wdata_q[7:0], 24'h0}; end
        2'b01:   begin sel_w = 4'b1100; wdata_w = {wdata_q[7:0], wdata_q[15:8], 16'h0}; end
        default: begin
          sel_w   = 4'b1111;
          wdata_w = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
        end
      endcase
    end
  end

  assign b0 = rdata_q[31:24];
  assign b1 = rdata_q[23:16];
  assign b2 = rdata_q[15:8];
  assign b3 = rdata_q[7:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_res = {{24{b0[7]}}, b0};
      3'b001:  load_res = {{16{b1[7]}}, b1, b0};
      3'b010:  load_res = {b3, b2, b1, b0};
      3'b100:  load_res = {24'h0, b0};
      3'b101:  load_res = {16'h0, b1, b0};
      default: load_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    stall_req  = 1'b0;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_sel    = 4'b0000;
    ram_wdata  = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall_req = req_valid;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        stall_req = 1'b1;
        // Gated by rst so a reset landing on ACCESS never commits a write.
        if (!err && rst) begin
          ram_ce    = 1'b1;
          ram_we    = store_q;
          ram_addr  = addr_q;
          ram_sel   = sel_w;
          ram_wdata = wdata_w;
        end
        state_d = RESP;
      end
      RESP: begin
        stall_req  = 1'b1;
        resp_valid = 1'b1;
        resp_err   = err;
        resp_data  = (err || store_q) ? '0 : load_res;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
